// File: rtl/jump_pkg.sv
// Shared types and constants for the jump controller: branch class encoding and
// the jump-target table (also the reset image when JUMP_LUT_WR_EN is defined).
package jump_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BRZ  = 3'd1,
    BR_JMP  = 3'd2,
    BR_CALL = 3'd3,
    BR_RET  = 3'd4
  } br_op_t;

  localparam int D_DEF     = 12;
  localparam int LUT_W_DEF = 5;
  localparam int LUT_N_DEF = 1 << LUT_W_DEF;

  // BRZ entries are two's-complement offsets, JMP/CALL entries absolute addresses.
  localparam logic [D_DEF-1:0] JUMP_LUT [LUT_N_DEF] = '{
    12'h000, 12'h004, 12'h010, 12'h0F0, 12'hFFC, 12'h200, 12'h3A0, 12'h07E,
    12'h100, 12'hFF8, 12'h0A5, 12'h5A5, 12'h800, 12'h7FF, 12'hFFF, 12'h001,
    12'h020, 12'h040, 12'h080, 12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF,
    12'h0C0, 12'hF00, 12'h00F, 12'h0FF, 12'h333, 12'h666, 12'h999, 12'hCCC
  };

endpackage

// File: rtl/jump_ctrl_ret_stack.sv
// Hardware return-address stack; push when full and pop when empty are ignored.
module ret_stack #(
  parameter int D         = 12,
  parameter int RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] push_data,
  output logic [D-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int SP_W  = $clog2(RAS_DEPTH + 1);
  localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [SP_W-1:0]  sp;
  logic [D-1:0]     mem [RAS_DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;

  assign empty   = (sp == '0);
  assign full    = (sp == SP_W'(RAS_DEPTH));
  assign wr_idx  = IDX_W'(sp);
  assign top_idx = IDX_W'(sp - SP_W'(1));
  assign top     = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) mem[IDX_W'(i)] <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= push_data;
      sp          <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      // Popped entry is left in place; only the pointer moves.
      sp <= sp - SP_W'(1);
    end
  end

endmodule

// File: rtl/jump_ctrl.sv
// Control-flow resolver feeding the program counter: LUT-based jumps/branches plus CALL/RET stack.
// Define JUMP_LUT_WR_EN to make the jump table writable (reset reloads the package image).
module jump_ctrl
  import jump_pkg::*;
#(
  parameter int D         = D_DEF,
  parameter int LUT_W     = LUT_W_DEF,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       br_op,
  input  logic             zero_flag,
  input  logic [LUT_W-1:0] lut_idx,
  input  logic [D-1:0]     prog_ctr,
`ifdef JUMP_LUT_WR_EN
  input  logic             lut_we,
  input  logic [LUT_W-1:0] lut_waddr,
  input  logic [D-1:0]     lut_wdata,
`endif
  output logic             branch_en,
  output logic             reljump_en,
  output logic             absjump_en,
  output logic [D-1:0]     target,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  localparam int LUT_N = 1 << LUT_W;

  logic [D-1:0] lut_val;
  logic [D-1:0] ras_top;
  logic         push;
  logic         pop;
  br_op_t       op;

`ifdef JUMP_LUT_WR_EN
  logic [D-1:0] lut_q [LUT_N];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LUT_N; i++) lut_q[LUT_W'(i)] <= D'(JUMP_LUT[LUT_W_DEF'(i)]);
    end else if (lut_we) begin
      lut_q[lut_waddr] <= lut_wdata;
    end
  end

  assign lut_val = lut_q[lut_idx];
`else
  assign lut_val = D'(JUMP_LUT[LUT_W_DEF'(lut_idx)]);
`endif

  always_comb begin
    case (br_op)
      3'd1:    op = BR_BRZ;
      3'd2:    op = BR_JMP;
      3'd3:    op = BR_CALL;
      3'd4:    op = BR_RET;
      default: op = BR_NONE;
    endcase
  end

  assign push = (op == BR_CALL);
  assign pop  = (op == BR_RET);

  ret_stack #(
    .D         (D),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (prog_ctr + D'(1)),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_comb begin
    branch_en  = 1'b0;
    reljump_en = 1'b0;
    absjump_en = 1'b0;
    target     = '0;
    case (op)
      BR_BRZ: begin
        if (zero_flag) begin
          branch_en  = 1'b1;
          reljump_en = 1'b1;
          target     = lut_val;
        end
      end
      BR_JMP, BR_CALL: begin
        branch_en  = 1'b1;
        absjump_en = 1'b1;
        target     = lut_val;
      end
      BR_RET: begin
        // Empty stack: fall through rather than jump to a stale entry.
        if (!ras_empty) begin
          branch_en  = 1'b1;
          absjump_en = 1'b1;
          target     = ras_top;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ras_err <= 1'b0;
    end else if ((push && ras_full) || (pop && ras_empty)) begin
      ras_err <= 1'b1;
    end
  end

endmodule

// File: doc/jump_ctrl.md
Name: jump_ctrl

Overview:
- Control-flow resolver directly upstream of the program counter.
- Each cycle it takes the decoded control-flow class of the current instruction, the zero flag, a jump-table index and the current prog_ctr.
- It drives the counter's branch_en / reljump_en / absjump_en / target inputs.
- Holds a jump-target lookup table and a small hardware return-address stack (RAS) for CALL/RET.

Parameters:
- D, 12, program-counter / target width in bits.
- LUT_W, 5, jump-table index width (2**LUT_W entries of D bits).
- RAS_DEPTH, 4, return-address stack entries (>=1).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- br_op  input  3  control-flow class (br_op_t): NONE=0, BRZ=1, JMP=2, CALL=3, RET=4; codes 5-7 treated as NONE.
- zero_flag  input  1  ALU zero flag for the current instruction.
- lut_idx  input  LUT_W  jump-table index from the instruction.
- prog_ctr  input  D  current PC value (address of the current instruction).
- branch_en  output  1  to PC: redirect this cycle.
- reljump_en  output  1  to PC: target is a two's-complement offset.
- absjump_en  output  1  to PC: target is an absolute address.
- target  output  D  to PC: offset or address.
- ras_empty  output  1  stack pointer == 0.
- ras_full  output  1  stack pointer == RAS_DEPTH.
- ras_err  output  1  sticky: overflow or underflow occurred since reset.

Behaviour:
- Redirect outputs are combinational from the inputs and current RAS/LUT state, so the PC consumes them at the same posedge. RAS and ras_err update on that posedge.
- Defaults when no redirect: branch_en=0, reljump_en=0, absjump_en=0, target=0.
- Invariants:
  - reljump_en and absjump_en are never both 1.
  - Either one implies branch_en=1.
  - branch_en=1 implies exactly one of them.
- NONE: defaults; no state change.
- BRZ:
  - zero_flag=1: branch_en=1, reljump_en=1, target=LUT[lut_idx] (D-bit two's-complement offset; PC adds modulo 2**D).
  - zero_flag=0: defaults.
- JMP: branch_en=1, absjump_en=1, target=LUT[lut_idx].
- CALL:
  - Redirect: as JMP.
  - Push (prog_ctr+1) mod 2**D; sp increments.
  - If ras_full: jump still taken, push dropped, sp unchanged, ras_err set.
- RET:
  - Not empty: branch_en=1, absjump_en=1, target=RAS[sp-1]; sp decrements.
  - Empty: defaults (PC falls through), ras_err set.
- Stack pointer: width $clog2(RAS_DEPTH+1), range 0..RAS_DEPTH, never wraps.
- Entry contents are not cleared on pop.
- Reset (priority over everything, including mid-CALL/RET):
  - sp=0, ras_err=0, RAS entries=0.
  - Outputs follow the current inputs; with br_op=NONE all outputs are 0, ras_empty=1, ras_full=0.
- During reset cycles, CALL/RET do not modify state.
- ras_err is cleared only by reset.

Optional Feature:
- Macro: JUMP_LUT_WR_EN.
- Defined:
  - Adds ports lut_we (in, 1), lut_waddr (in, LUT_W), lut_wdata (in, D).
  - LUT is a register array loaded from the package constant on reset.
  - Write at posedge when lut_we=1 and reset=0.
  - Same-cycle read of the written index returns the old value; the new value is visible the next cycle.
- Undefined: ports absent; LUT is the package constant (pure ROM), no flops.

Decomposition:
- Package jump_pkg:
  - br_op_t enum (3-bit).
  - Default D and LUT_W localparams.
  - JUMP_LUT constant array (2**LUT_W x D), reset image for the optional write port.
- Sub-module ret_stack:
  - Parameters D and RAS_DEPTH.
  - Ports clk, reset, push, pop, push_data, top, empty, full.
  - Push when full and pop when empty are ignored internally.
- jump_ctrl derives ras_err from push&full / pop&empty.

Test Plan:
- Reset, then br_op=NONE -> all redirect outputs 0; ras_empty=1, ras_full=0, ras_err=0.
- JUMP_LUT[3]=12'h0F0; br_op=JMP, lut_idx=3 -> branch_en=1, absjump_en=1, target=0x0F0. br_op=BRZ, idx=3, zero_flag=0 -> no redirect. zero_flag=1 with LUT[4]=12'hFFC -> reljump_en=1, target=0xFFC (-4).
- CALL idx=3 at prog_ctr=0x010 -> target 0x0F0, sp=1. Then RET -> absjump_en=1, target=0x011, ras_empty=1 after the edge. CALL at prog_ctr=0xFFF pushes 0x000.
- RAS_DEPTH=4: five CALLs at prog_ctr 0x01..0x05 -> fifth jumps, ras_full=1, ras_err=1. Five RETs -> targets 0x05,0x04,0x03,0x02; fifth RET gives no redirect.
- RET on empty after reset -> branch_en=0, ras_err=1 next cycle and holding. CALL with reset=1 -> sp stays 0.
- With JUMP_LUT_WR_EN: write idx=7 data 0x123 while JMP idx=7 in the same cycle -> old value on target; next cycle JMP idx=7 -> 0x123. Reset -> reverts to the package value.
